// File: rtl/shift_out_if.sv
// Handshake and serial-pin bundle between the CPU-side requester and the
// 74HC595-style chain driver.
interface shift_out_if;
   logic [31:0] data_in;
   logic        valid;
   logic        ready;
   logic        done;
   logic        sr_clk;
   logic        sr_data;
   logic        sr_latch;

   modport master (output data_in, valid,
                   input  ready, done, sr_clk, sr_data, sr_latch);
   modport slave  (input  data_in, valid,
                   output ready, done, sr_clk, sr_data, sr_latch);
endinterface

// File: rtl/shift_out_driver.sv
// Bit-bangs an NBITS-wide word MSB first into a serial-in/parallel-out chain,
// then pulses the storage latch. All pin outputs are registered.
module shift_out_driver #(
   parameter int NBITS   = 32,
   parameter int CLK_DIV = 32
) (
   input logic        clk,
   input logic        reset,
   shift_out_if.slave bus
);
   localparam logic [1:0]  IDLE     = 2'd0;
   localparam logic [1:0]  SHIFT_LO = 2'd1;
   localparam logic [1:0]  SHIFT_HI = 2'd2;
   localparam logic [1:0]  LATCH    = 2'd3;
   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [4:0]  IDX_LAST = 5'(NBITS - 1);

   logic [1:0]       state;
   logic [15:0]      cnt;
   logic [4:0]       idx;
   logic [NBITS-1:0] shreg;
   logic [NBITS-1:0] sh_next;
   logic             ready_q, done_q, clk_q, data_q, latch_q;

   assign sh_next = shreg << 1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         clk_q   <= 1'b0;
         data_q  <= 1'b0;
         latch_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               // ready is always high here, so valid alone means accept
               if (bus.valid) begin
                  shreg   <= bus.data_in[NBITS-1:0];
                  data_q  <= bus.data_in[NBITS-1];
                  idx     <= '0;
                  cnt     <= '0;
                  ready_q <= 1'b0;
                  state   <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (cnt == DIV_LAST) begin
                  cnt   <= '0;
                  clk_q <= 1'b1;
                  state <= SHIFT_HI;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            SHIFT_HI: begin
               if (cnt == DIV_LAST) begin
                  cnt   <= '0;
                  clk_q <= 1'b0;
                  if (idx == IDX_LAST) begin
                     data_q  <= 1'b0;
                     latch_q <= 1'b1;
                     state   <= LATCH;
                  end else begin
                     // data moves only on the falling edge, giving a full
                     // half-period of setup before the next rising edge
                     shreg  <= sh_next;
                     data_q <= sh_next[NBITS-1];
                     idx    <= idx + 5'd1;
                     state  <= SHIFT_LO;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               if (cnt == DIV_LAST) begin
                  cnt     <= '0;
                  latch_q <= 1'b0;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
         endcase
      end
   end

   assign bus.ready    = ready_q;
   assign bus.done     = done_q;
   assign bus.sr_clk   = clk_q;
   assign bus.sr_data  = data_q;
   assign bus.sr_latch = latch_q;
endmodule

// File: tb/tb_shift_out_driver.sv
// Four driver configurations run side by side, each checked every cycle
// against a frame-timing model plus a 74HC595 chain model on its pins.
module tb_shift_out_driver;
   logic        clk = 1'b0;
   logic [31:0] din_a[4];
   logic        vld_a[4];
   logic        rst_a[4];
   logic        done_w[4];
   bit          live = 1'b0;
   int          cmp = 0;
   int          mis = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : g_i
      localparam int NB = (g == 0) ? 8 : ((g == 3) ? 1 : 32);
      localparam int CD = (g == 0) ? 2 : ((g == 2) ? 4 : 1);
      localparam int L  = 2 * CD * NB + CD;
      localparam logic [31:0] MASK = 32'((64'd1 << NB) - 64'd1);

      shift_out_if ifc();
      assign ifc.data_in = din_a[g];
      assign ifc.valid   = vld_a[g];
      assign done_w[g]   = ifc.done;

      shift_out_driver #(.NBITS(NB), .CLK_DIV(CD)) dut (
         .clk(clk), .reset(rst_a[g]), .bus(ifc));

      // frame model: k counts cycles since the accept edge
      bit          busy = 1'b0, dn = 1'b0;
      int          k = 0;
      logic [31:0] word = '0;

      always @(posedge clk) begin
         if (rst_a[g]) begin
            busy = 1'b0; k = 0; dn = 1'b0;
         end else if (busy) begin
            k++;
            if (k > L) begin busy = 1'b0; k = 0; dn = 1'b1; end
         end else begin
            dn = 1'b0;
            if (vld_a[g]) begin busy = 1'b1; k = 1; word = din_a[g]; end
         end
      end

      logic [31:0] chain = '0, storage = '0, cap = '0;
      int          rise_cnt = 0, lat_cnt = 0, latrun = 0, latch_run = 0;
      int          lowc = 0, low_last = 0, highc = 0, high_last = 0;
      logic        pclk = 1'b0, plat = 1'b0, pready = 1'b1;

      always @(negedge clk) begin
         logic [4:0] exp, act;
         int b;
         bit hi;
         if (live) begin
            if (!busy) exp = {1'b1, dn, 3'b000};
            else if (k <= 2 * CD * NB) begin
               b  = (k - 1) / (2 * CD);
               hi = ((k - 1) % (2 * CD)) >= CD;
               exp = {2'b00, hi, word[NB-1-b], 1'b0};
            end else exp = 5'b00001;
            act = {ifc.ready, ifc.done, ifc.sr_clk, ifc.sr_data, ifc.sr_latch};
            chk($sformatf("pins%0d k=%0d", g, k), 32'(act), 32'(exp));

            if (ifc.sr_clk && !pclk) begin
               chain = {chain[30:0], ifc.sr_data};
               cap   = {cap[30:0], ifc.sr_data};
               rise_cnt++;
            end
            if (ifc.sr_latch && !plat) begin storage = chain & MASK; lat_cnt++; end
            if (ifc.sr_latch) latrun++;
            else if (plat) begin latch_run = latrun; latrun = 0; end
            if (!ifc.ready) lowc++;
            else if (!pready) begin low_last = lowc; lowc = 0; end
            if (ifc.ready) highc++;
            else if (pready) begin high_last = highc; highc = 0; end
            pclk = ifc.sr_clk; plat = ifc.sr_latch; pready = ifc.ready;
         end
      end
   end

   task automatic wait_done(input int g, input int lim);
      int n = 0;
      do begin @(negedge clk); n++; end while (!done_w[g] && n < lim);
      chk($sformatf("done_seen%0d", g), 32'(done_w[g]), 32'd1);
   endtask

   task automatic pulse(input int g, input logic [31:0] d);
      @(negedge clk); din_a[g] = d; vld_a[g] = 1'b1;
      @(negedge clk); vld_a[g] = 1'b0; din_a[g] = '0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 4; i++) begin din_a[i] = '0; vld_a[i] = 1'b0; rst_a[i] = 1'b1; end
      repeat (3) @(negedge clk);
      chk("reset_pins", 32'({g_i[0].ifc.ready, g_i[0].ifc.done, g_i[0].ifc.sr_clk,
                             g_i[0].ifc.sr_data, g_i[0].ifc.sr_latch}), 32'b10000);
      live = 1'b1;
      for (int i = 0; i < 4; i++) rst_a[i] = 1'b0;
      repeat (20) @(negedge clk);
      chk("idle_activity", 32'(g_i[0].rise_cnt + g_i[1].rise_cnt + g_i[2].rise_cnt
                              + g_i[3].rise_cnt + g_i[0].lat_cnt), 32'd0);

      // 8-bit frame, CLK_DIV=2, with a busy request that must be ignored
      pulse(0, 32'hA5);
      repeat (10) @(negedge clk);
      pulse(0, 32'hFF);
      wait_done(0, 200);
      @(negedge clk);
      chk("a5_bits", g_i[0].cap & 32'hFF, 32'hA5);
      chk("a5_edges", 32'(g_i[0].rise_cnt), 32'd8);
      chk("a5_store", g_i[0].storage, 32'hA5);
      chk("a5_latches", 32'(g_i[0].lat_cnt), 32'd1);
      chk("a5_latch_len", 32'(g_i[0].latch_run), 32'd2);
      chk("a5_busy_len", 32'(g_i[0].low_last), 32'd34);

      // back-to-back, 32 bits, CLK_DIV=1, valid held across the done cycle
      @(negedge clk); din_a[1] = 32'hDEADBEEF; vld_a[1] = 1'b1;
      @(negedge clk); din_a[1] = 32'h12345678;
      wait_done(1, 200);
      @(negedge clk); vld_a[1] = 1'b0;
      chk("b2b_store1", g_i[1].storage, 32'hDEADBEEF);
      chk("b2b_busy1", 32'(g_i[1].low_last), 32'd65);
      wait_done(1, 200);
      @(negedge clk);
      chk("b2b_store2", g_i[1].storage, 32'h12345678);
      chk("b2b_latches", 32'(g_i[1].lat_cnt), 32'd2);
      chk("b2b_busy2", 32'(g_i[1].low_last), 32'd65);
      chk("b2b_gap", 32'(g_i[1].high_last), 32'd1);

      // reset after 10 shift edges abandons the frame
      pulse(2, 32'hFFFFFFFF);
      n = 0;
      while (g_i[2].rise_cnt < 10 && n < 1000) begin @(negedge clk); n++; end
      chk("mid_edges_reached", 32'(g_i[2].rise_cnt >= 10), 32'd1);
      rst_a[2] = 1'b1;
      @(negedge clk); rst_a[2] = 1'b0;
      chk("mid_reset_pins", 32'({g_i[2].ifc.ready, g_i[2].ifc.done, g_i[2].ifc.sr_clk,
                                 g_i[2].ifc.sr_data, g_i[2].ifc.sr_latch}), 32'b10000);
      repeat (5) @(negedge clk);
      chk("mid_no_latch", 32'(g_i[2].lat_cnt), 32'd0);
      chk("mid_store_kept", g_i[2].storage, 32'd0);
      pulse(2, 32'h0000000F);
      wait_done(2, 1000);
      @(negedge clk);
      chk("mid_next_store", g_i[2].storage, 32'h0000000F);
      chk("mid_next_latches", 32'(g_i[2].lat_cnt), 32'd1);

      // single-bit frame at full rate
      pulse(3, 32'h1);
      wait_done(3, 50);
      @(negedge clk);
      chk("nb1_busy_len", 32'(g_i[3].low_last), 32'd3);
      chk("nb1_edges", 32'(g_i[3].rise_cnt), 32'd1);
      chk("nb1_bit", g_i[3].cap & 32'h1, 32'h1);
      chk("nb1_store", g_i[3].storage, 32'h1);
      chk("nb1_latch_len", 32'(g_i[3].latch_run), 32'd1);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
   end
endmodule
